// File: rtl/oam_dma_engine_pkg.sv
// Shared types and constants for the OAM DMA engine and its address generator.
package oam_dma_engine_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_REQ,
    DMA_RD_ADDR,
    DMA_RD_CAP,
    DMA_WR_ADDR,
    DMA_WR_COMMIT,
    DMA_DONE
  } dma_state_t;

  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [7:0]  OAM_LEN      = 8'd160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

  // Echo RAM E000-FFFF mirrors C000-DFFF, so those pages are read 0x20 pages lower.
  function automatic logic [7:0] mapSrcHi(input logic [7:0] srcHi);
    return (srcHi < 8'hE0) ? srcHi : (srcHi - 8'h20);
  endfunction

endpackage

// File: rtl/oam_dma_addr_gen.sv
// Source page latch, byte index counter and source/destination address formation.
// Addresses are produced from the next-cycle values so the engine can register them.
module oam_dma_addr_gen
  import oam_dma_engine_pkg::*;
#(
  parameter logic [7:0]  LEN      = OAM_LEN,
  parameter logic [15:0] DST_BASE = OAM_BASE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [7:0]  i_src_hi,
  input  logic        i_advance,
  output logic [15:0] o_rd_addr_next,
  output logic [15:0] o_wr_addr_next,
  output logic        o_last
);

  logic [7:0] r_srcHi;
  logic [7:0] r_index;
  logic [7:0] w_srcHiNext;
  logic [7:0] w_indexNext;

  assign o_last = (r_index == (LEN - 8'd1));

  // A load restarts at byte 0 of a new page; advancing stops at the last byte instead of wrapping.
  always_comb begin
    w_srcHiNext = r_srcHi;
    w_indexNext = r_index;
    if (i_load) begin
      w_srcHiNext = i_src_hi;
      w_indexNext = 8'd0;
    end else if (i_advance && !o_last) begin
      w_indexNext = r_index + 8'd1;
    end
  end

  // Source page and index registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_srcHi <= 8'd0;
      r_index <= 8'd0;
    end else begin
      r_srcHi <= w_srcHiNext;
      r_index <= w_indexNext;
    end
  end

  assign o_rd_addr_next = {mapSrcHi(w_srcHiNext), w_indexNext};
  assign o_wr_addr_next = DST_BASE + {8'h00, w_indexNext};

endmodule

// File: rtl/oam_dma_engine.sv
// OAM DMA bus initiator: copies LEN bytes from page {src_hi,00} into OAM through the
// memory unit's CPU-side port. Each byte is a read (present + capture) then a write
// (present + commit). Outputs are registered from the next state; oe/we are additionally
// gated by the grant so the port goes quiet the moment the arbiter takes it back.
module oam_dma_engine
  import oam_dma_engine_pkg::*;
#(
  parameter logic [7:0]  LEN      = OAM_LEN,
  parameter logic [15:0] DST_BASE = OAM_BASE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_dma_start,
  input  logic [7:0]  i_dma_src_hi,
  input  logic        i_bus_grant,
  output logic        o_bus_req,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_oe,
  output logic        o_mem_we,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata,
  output logic        o_dma_active,
  output logic        o_dma_done
);

  dma_state_t  r_state;
  dma_state_t  w_stateNext;
  logic        w_load;
  logic        w_advance;
  logic        w_capture;
  logic        w_last;
  logic [15:0] w_rdAddrNext;
  logic [15:0] w_wrAddrNext;
  logic        w_isRd;
  logic        w_isWr;
  logic [7:0]  w_byteBufNext;
  logic [15:0] w_addrNext;
  logic [7:0]  w_wdataNext;

  logic [7:0]  r_byteBuf;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_busReq;
  logic        r_oe;
  logic        r_we;
  logic        r_active;
  logic        r_done;

  oam_dma_addr_gen #(
    .LEN      (LEN),
    .DST_BASE (DST_BASE)
  ) u_addr_gen (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_load         (w_load),
    .i_src_hi       (i_dma_src_hi),
    .i_advance      (w_advance),
    .o_rd_addr_next (w_rdAddrNext),
    .o_wr_addr_next (w_wrAddrNext),
    .o_last         (w_last)
  );

  // Next state and next output values; a start always restarts, a lost grant rewinds to the present phase.
  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_capture   = 1'b0;
    if (i_dma_start) begin
      w_stateNext = DMA_REQ;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        DMA_IDLE:      w_stateNext = DMA_IDLE;
        DMA_REQ:       if (i_bus_grant) w_stateNext = DMA_RD_ADDR;
        DMA_RD_ADDR:   if (i_bus_grant) w_stateNext = DMA_RD_CAP;
        DMA_RD_CAP: begin
          if (i_bus_grant) begin
            w_capture   = 1'b1;
            w_stateNext = DMA_WR_ADDR;
          end else begin
            w_stateNext = DMA_RD_ADDR;
          end
        end
        DMA_WR_ADDR:   if (i_bus_grant) w_stateNext = DMA_WR_COMMIT;
        DMA_WR_COMMIT: begin
          if (i_bus_grant) begin
            w_advance   = 1'b1;
            w_stateNext = w_last ? DMA_DONE : DMA_RD_ADDR;
          end else begin
            w_stateNext = DMA_WR_ADDR;
          end
        end
        DMA_DONE:      w_stateNext = DMA_IDLE;
        default:       w_stateNext = DMA_IDLE;
      endcase
    end

    w_isRd        = (w_stateNext == DMA_RD_ADDR) || (w_stateNext == DMA_RD_CAP);
    w_isWr        = (w_stateNext == DMA_WR_ADDR) || (w_stateNext == DMA_WR_COMMIT);
    w_byteBufNext = w_capture ? i_mem_rdata : r_byteBuf;
    w_addrNext    = r_addr;
    if (w_isRd) begin
      w_addrNext = w_rdAddrNext;
    end else if (w_isWr) begin
      w_addrNext = w_wrAddrNext;
    end
    w_wdataNext = w_isWr ? w_byteBufNext : r_wdata;
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= DMA_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Registered bus outputs and the byte buffer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_byteBuf <= 8'd0;
      r_addr    <= 16'd0;
      r_wdata   <= 8'd0;
      r_busReq  <= 1'b0;
      r_oe      <= 1'b0;
      r_we      <= 1'b0;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_byteBuf <= w_byteBufNext;
      r_addr    <= w_addrNext;
      r_wdata   <= w_wdataNext;
      r_busReq  <= (w_stateNext != DMA_IDLE) && (w_stateNext != DMA_DONE);
      r_oe      <= w_isRd;
      r_we      <= w_isWr;
      r_active  <= (w_stateNext != DMA_IDLE);
      r_done    <= (w_stateNext == DMA_DONE);
    end
  end

  assign o_bus_req    = r_busReq;
  assign o_mem_addr   = r_addr;
  assign o_mem_oe     = r_oe & i_bus_grant;
  assign o_mem_we     = r_we & i_bus_grant;
  assign o_mem_wdata  = r_wdata;
  assign o_dma_active = r_active;
  assign o_dma_done   = r_done;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: a 64 KiB memory model with a registered address and a
// two-cycle write commit, a transfer-level reference model, a per-cycle compare process,
// and directed scenarios (basic, echo source, grant stall, restart, reset abort).
module tb_oam_dma_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmaStart = 1'b0;
  logic [7:0]  srcHi = 8'd0;
  logic        busGrant = 1'b1;
  logic        busReq;
  logic [15:0] memAddr;
  logic        memOe;
  logic        memWe;
  logic [7:0]  memWdata;
  logic [7:0]  memRdata;
  logic        dmaActive;
  logic        dmaDone;

  logic [7:0]  mem [0:65535];
  logic [15:0] latchAddr = 16'd0;
  logic        latchWe = 1'b0;
  int          wrCount [0:255];
  int          totalWrites = 0;
  int          rdE1 = 0;
  int          rdC1 = 0;
  int          doneCount = 0;
  int          lastDoneCycle = 0;
  int          cycle = 0;
  int          startCycle = 0;
  int          total = 0;
  int          bad = 0;

  int          mMode = 0;
  int          mByte = 0;
  int          mPhase = 0;
  logic [7:0]  mSrc = 8'd0;
  logic [15:0] mAddr = 16'd0;
  logic [7:0]  mWdata = 8'd0;

  logic        expOe;
  logic        expWe;
  logic        expReq;
  logic        expActive;
  logic        expDone;

  oam_dma_engine dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_dma_start  (dmaStart),
    .i_dma_src_hi (srcHi),
    .i_bus_grant  (busGrant),
    .o_bus_req    (busReq),
    .o_mem_addr   (memAddr),
    .o_mem_oe     (memOe),
    .o_mem_we     (memWe),
    .o_mem_wdata  (memWdata),
    .i_mem_rdata  (memRdata),
    .o_dma_active (dmaActive),
    .o_dma_done   (dmaDone)
  );

  always #5 clk = ~clk;

  // Source contents: low byte ^ 5A ^ (page - C0), so C0xx holds i^5A and every page differs.
  function automatic logic [7:0] pat(input logic [15:0] a);
    logic [7:0] hiOff;
    hiOff = a[15:8] - 8'hC0;
    return a[7:0] ^ 8'h5A ^ hiOff;
  endfunction

  function automatic logic [7:0] mapHi(input logic [7:0] h);
    if (h >= 8'hE0) return h - 8'h20;
    return h;
  endfunction

  function automatic int oamMismatch(input logic [7:0] page, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      if (mem[16'hFE00 + 16'(i)] !== pat({page, 8'(i)})) n++;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] src);
    @(posedge clk); #1;
    dmaStart   = 1'b1;
    srcHi      = src;
    startCycle = cycle;
    @(posedge clk); #1;
    dmaStart   = 1'b0;
  endtask

  task automatic waitModel(input int b, input int ph, input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(mMode == 2 && mByte == b && mPhase == ph) && n < budget);
    if (n >= budget) checkOutput("waitModelTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitDone(input int budget, output int latency);
    int snap = doneCount;
    int n = 0;
    while (doneCount == snap && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (doneCount == snap) checkOutput("doneTimeout", 32'd0, 32'd1);
    latency = lastDoneCycle - startCycle;
  endtask

  // Free-running cycle counter.
  always @(posedge clk) cycle <= cycle + 1;

  // Memory unit: address/we registered each edge; a write commits when we is held for two cycles.
  assign memRdata = mem[latchAddr];
  always @(posedge clk) begin
    if (latchWe && memWe && latchAddr == memAddr) begin
      mem[latchAddr] <= memWdata;
      totalWrites    <= totalWrites + 1;
      if (latchAddr[15:8] == 8'hFE) wrCount[latchAddr[7:0]] <= wrCount[latchAddr[7:0]] + 1;
    end
    latchAddr <= memAddr;
    latchWe   <= memWe;
  end

  // Transfer-level reference: mode 0 idle, 1 request, 2 byte phases 0..3, 3 done.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mMode = 0; mByte = 0; mPhase = 0; mSrc = 8'd0; mAddr = 16'd0; mWdata = 8'd0;
    end else begin
      if (dmaStart) begin
        mMode = 1; mSrc = srcHi; mByte = 0; mPhase = 0;
      end else if (mMode == 1) begin
        if (busGrant) begin mMode = 2; mByte = 0; mPhase = 0; end
      end else if (mMode == 2) begin
        if (!busGrant) mPhase = (mPhase >= 2) ? 2 : 0;
        else if (mPhase == 3) begin
          if (mByte == 159) mMode = 3;
          else begin mByte = mByte + 1; mPhase = 0; end
        end else mPhase = mPhase + 1;
      end else if (mMode == 3) begin
        mMode = 0;
      end
      if (mMode == 2) begin
        if (mPhase < 2) mAddr = {mapHi(mSrc), 8'(mByte)};
        else begin
          mAddr  = 16'hFE00 + 16'(mByte);
          mWdata = pat({mapHi(mSrc), 8'(mByte)});
        end
      end
    end
  end

  // Compare every cycle against the reference, plus bus protocol rules.
  always @(negedge clk) begin
    expReq    = (mMode == 1) || (mMode == 2);
    expActive = (mMode != 0);
    expDone   = (mMode == 3);
    expOe     = (mMode == 2) && (mPhase < 2) && busGrant;
    expWe     = (mMode == 2) && (mPhase >= 2) && busGrant;
    checkOutput("busReq", 32'(busReq), 32'(expReq));
    checkOutput("dmaActive", 32'(dmaActive), 32'(expActive));
    checkOutput("dmaDone", 32'(dmaDone), 32'(expDone));
    checkOutput("memOe", 32'(memOe), 32'(expOe));
    checkOutput("memWe", 32'(memWe), 32'(expWe));
    checkOutput("memAddr", 32'(memAddr), 32'(mAddr));
    checkOutput("memWdata", 32'(memWdata), 32'(mWdata));
    checkOutput("oeWeExclusive", 32'(memOe & memWe), 32'd0);
    checkOutput("weNeedsGrant", 32'(memWe & ~busGrant), 32'd0);
    checkOutput("activeMatchesReq", 32'(dmaActive & ~dmaDone), 32'(busReq));
    if (dmaDone) begin
      doneCount     = doneCount + 1;
      lastDoneCycle = cycle;
    end
    if (memOe && memAddr[15:8] == 8'hE1) rdE1 = rdE1 + 1;
    if (memOe && memAddr[15:8] == 8'hC1) rdC1 = rdC1 + 1;
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int lat;
    int snap;
    int snap2;

    for (int a = 0; a < 65536; a++) begin
      mem[a] = (a >= 32'hFE00) ? 8'hA5 : ((a >= 32'h8000) ? pat(16'(a)) : 8'h00);
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("resetBusReq", 32'(busReq), 32'd0);
    checkOutput("resetAddr", 32'(memAddr), 32'd0);
    checkOutput("resetActive", 32'(dmaActive), 32'd0);
    checkOutput("resetWdata", 32'(memWdata), 32'd0);

    $display("[TB] basic transfer from C0");
    snap  = doneCount;
    snap2 = totalWrites;
    applyStimulus(8'hC0);
    waitDone(800, lat);
    checkOutput("basicLatency", 32'(lat), 32'd642);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("basicDonePulses", 32'(doneCount - snap), 32'd1);
    checkOutput("basicWrites", 32'(totalWrites - snap2), 32'd160);
    checkOutput("basicOam", 32'(oamMismatch(8'hC0, 0, 159)), 32'd0);
    checkOutput("basicFE00", 32'(mem[16'hFE00]), 32'h5A);
    checkOutput("basicFE9F", 32'(mem[16'hFE9F]), 32'hC5);
    checkOutput("basicFEA0", 32'(mem[16'hFEA0]), 32'hA5);
    checkOutput("basicFEA0Writes", 32'(wrCount[8'hA0]), 32'd0);

    $display("[TB] echo source E1");
    snap  = rdE1;
    snap2 = rdC1;
    applyStimulus(8'hE1);
    waitDone(800, lat);
    checkOutput("echoLatency", 32'(lat), 32'd642);
    checkOutput("echoReadsE1", 32'(rdE1 - snap), 32'd0);
    checkOutput("echoReadsC1", 32'(rdC1 - snap2), 32'd320);
    checkOutput("echoOam", 32'(oamMismatch(8'hC1, 0, 159)), 32'd0);
    checkOutput("echoFE00", 32'(mem[16'hFE00]), 32'h5B);

    $display("[TB] grant stall at byte 50");
    snap = wrCount[50];
    applyStimulus(8'hC2);
    waitModel(50, 2, 700);
    busGrant = 1'b0;
    repeat (10) @(posedge clk);
    #1 busGrant = 1'b1;
    waitDone(800, lat);
    checkOutput("stallLatency", 32'(lat), 32'd652);
    checkOutput("stallByte50Writes", 32'(wrCount[50] - snap), 32'd1);
    checkOutput("stallOam", 32'(oamMismatch(8'hC2, 0, 159)), 32'd0);
    checkOutput("stallFE32", 32'(mem[16'hFE32]), 32'h6A);

    $display("[TB] restart 80 -> D0 at byte 20");
    snap = doneCount;
    applyStimulus(8'h80);
    waitModel(20, 0, 700);
    applyStimulus(8'hD0);
    waitDone(800, lat);
    checkOutput("restartLatency", 32'(lat), 32'd642);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("restartDonePulses", 32'(doneCount - snap), 32'd1);
    checkOutput("restartOam", 32'(oamMismatch(8'hD0, 0, 159)), 32'd0);
    checkOutput("restartFE00", 32'(mem[16'hFE00]), 32'h4A);

    $display("[TB] reset abort at byte 77");
    applyStimulus(8'hC1);
    waitModel(77, 0, 700);
    rst = 1'b1;
    #1;
    checkOutput("abortBusReq", 32'(busReq), 32'd0);
    checkOutput("abortOe", 32'(memOe), 32'd0);
    checkOutput("abortWe", 32'(memWe), 32'd0);
    checkOutput("abortAddr", 32'(memAddr), 32'd0);
    checkOutput("abortWdata", 32'(memWdata), 32'd0);
    checkOutput("abortActive", 32'(dmaActive), 32'd0);
    checkOutput("abortDone", 32'(dmaDone), 32'd0);
    snap = totalWrites;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abortNoWrites", 32'(totalWrites - snap), 32'd0);
    checkOutput("abortOamHead", 32'(oamMismatch(8'hC1, 0, 76)), 32'd0);
    checkOutput("abortOamTail", 32'(oamMismatch(8'hD0, 77, 159)), 32'd0);
    checkOutput("abortFE4C", 32'(mem[16'hFE4C]), 32'h17);
    checkOutput("abortFE4D", 32'(mem[16'hFE4D]), 32'h07);

    $display("[TB] transfer after reset");
    applyStimulus(8'hC0);
    waitDone(800, lat);
    checkOutput("postResetLatency", 32'(lat), 32'd642);
    checkOutput("postResetOam", 32'(oamMismatch(8'hC0, 0, 159)), 32'd0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
